// File: rtl/pulse_seq_pkg.sv
// Shared types, width defaults and the reset-divisor helper for the pulse sequencer.
// Consumers import pulse_seq_pkg::* to pick up the state type and defaults.
package pulse_seq_pkg;

  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_BURST_W    = 16;
  localparam int unsigned DEF_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_PULSE_FREQ = 100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Zero pulse_freq yields 0 so the elaboration check in the top catches it.
  function automatic int unsigned default_div(input int unsigned clk_freq,
                                              input int unsigned pulse_freq);
    if (pulse_freq == 0) begin
      return 0;
    end
    return clk_freq / pulse_freq;
  endfunction

endpackage

// File: rtl/pulse_tick_counter.sv
// Free-running cycle counter with synchronous clear, enable and a runtime terminal value.
// o_tick is high in the cycle the count sits at the terminal value while enabled.
module pulse_tick_counter
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_term;

  assign w_at_term = (r_cnt == i_term);
  assign o_tick    = i_en && w_at_term;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_term ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Run-time configurable pulse generator: divisor/burst loaded over a valid/ready port,
// then single-cycle pulses every N clocks, continuously or for a fixed burst.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned PULSE_FREQ = DEF_PULSE_FREQ,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned BURST_W    = DEF_BURST_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CNT_W-1:0]   i_cfg_div,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_pulse_out,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_pulse_cnt,
  output logic               o_err
);

  localparam int unsigned      DEF_DIV = default_div(CLK_FREQ, PULSE_FREQ);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEF_DIV);

  if (DEF_DIV < 1) begin : g_div_check
    $error("pulse_sequencer: CLK_FREQ/PULSE_FREQ must be at least 1");
  end

  state_e             r_state;
  state_e             w_next_state;
  logic [CNT_W-1:0]   r_div;
  logic [BURST_W-1:0] r_burst;
  logic               r_pulse_out;
  logic               r_busy;
  logic               r_done;
  logic [BURST_W-1:0] r_pulse_cnt;
  logic               r_err;

  logic               w_idle;
  logic               w_run;
  logic               w_cfg_hs;
  logic               w_cfg_legal;
  logic               w_start;
  logic               w_run_en;
  logic               w_tick;
  logic [CNT_W-1:0]   w_term;
  logic [BURST_W-1:0] w_pcnt_inc;
  logic               w_burst_end;

  assign w_idle      = (r_state == S_IDLE);
  assign w_run       = (r_state == S_RUN);
  assign w_cfg_hs    = i_cfg_valid && w_idle;
  assign w_cfg_legal = (i_cfg_div != '0);
  assign w_start     = w_idle && i_start;
  // Stop outranks the tick, so the counter only advances on non-stop RUN edges.
  assign w_run_en    = w_run && !i_stop;
  assign w_term      = r_div - CNT_W'(1);
  assign w_pcnt_inc  = r_pulse_cnt + BURST_W'(1);
  assign w_burst_end = w_tick && (r_burst != '0) && (w_pcnt_inc == r_burst);

  pulse_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!w_run_en),
    .i_en    (w_run_en),
    .i_term  (w_term),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_next_state = S_IDLE;
        end else if (w_burst_end) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pulse_out <= w_tick;
      r_busy      <= (w_next_state == S_RUN);
      r_done      <= w_burst_end;
    end
  end

  // An illegal divisor flags err but leaves the previous config in force.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= RST_DIV;
      r_burst <= '0;
      r_err   <= 1'b0;
    end else if (w_cfg_hs) begin
      r_err <= !w_cfg_legal;
      if (w_cfg_legal) begin
        r_div   <= i_cfg_div;
        r_burst <= i_cfg_burst;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pulse_cnt <= '0;
    end else if (w_start) begin
      r_pulse_cnt <= '0;
    end else if (w_tick) begin
      r_pulse_cnt <= w_pcnt_inc;
    end
  end

  assign o_cfg_ready = w_idle;
  assign o_pulse_out = r_pulse_out;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pulse_cnt = r_pulse_cnt;
  assign o_err       = r_err;

`ifndef SYNTHESIS
  a_done_is_last_pulse : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_done |-> (r_pulse_out && !r_busy));

  a_done_one_cycle : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == S_DONE) |=> (r_state == S_IDLE));

  a_pulse_single : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_pulse_out && (r_div != CNT_W'(1))) |=> !r_pulse_out);
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// stimulus compared every cycle against an edge-count/modulo reference model.
module tb_pulse_sequencer;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned PULSE_FREQ = 100;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned BURST_W    = 4;
  localparam int          PCNT_MOD   = 1 << BURST_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [CNT_W-1:0]   cfg_div = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               cfg_ready;
  logic               pulse_out;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] pulse_cnt;
  logic               err;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 run, 2 done; pulses fall on multiples of div
  // counted in edges since the start edge.
  int m_phase, m_k, m_div, m_burst, m_pcnt;
  bit m_pulse, m_done, m_err;

  always #5 clk = ~clk;

  pulse_sequencer #(
    .CLK_FREQ   (CLK_FREQ),
    .PULSE_FREQ (PULSE_FREQ),
    .CNT_W      (CNT_W),
    .BURST_W    (BURST_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_div   (cfg_div),
    .i_cfg_burst (cfg_burst),
    .i_start     (start),
    .i_stop      (stop),
    .o_pulse_out (pulse_out),
    .o_busy      (busy),
    .o_done      (done),
    .o_pulse_cnt (pulse_cnt),
    .o_err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_k     = 0;
    m_div   = CLK_FREQ / PULSE_FREQ;
    m_burst = 0;
    m_pcnt  = 0;
    m_pulse = 1'b0;
    m_done  = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        m_pulse = 1'b0;
        m_done  = 1'b0;
        if (cfg_valid) begin
          if (cfg_div != 0) begin
            m_div   = int'(cfg_div);
            m_burst = int'(cfg_burst);
            m_err   = 1'b0;
          end else begin
            m_err = 1'b1;
          end
        end
        if (start) begin
          m_phase = 1;
          m_k     = 0;
          m_pcnt  = 0;
        end
      end
      1: begin
        m_done = 1'b0;
        if (stop) begin
          m_phase = 0;
          m_pulse = 1'b0;
        end else begin
          m_k++;
          m_pulse = ((m_k % m_div) == 0);
          if (m_pulse) begin
            m_pcnt = (m_pcnt + 1) % PCNT_MOD;
            if (m_burst != 0 && m_pcnt == m_burst) begin
              m_phase = 2;
              m_done  = 1'b1;
            end
          end
        end
      end
      default: begin
        m_pulse = 1'b0;
        m_done  = 1'b0;
        m_phase = 0;
      end
    endcase
  endtask

  always @(negedge clk) begin
    check("pulse_out", 32'(pulse_out), 32'(m_pulse));
    check("busy",      32'(busy),      32'(m_phase == 1));
    check("done",      32'(done),      32'(m_done));
    check("pulse_cnt", 32'(pulse_cnt), 32'(m_pcnt));
    check("err",       32'(err),       32'(m_err));
    check("cfg_ready", 32'(cfg_ready), 32'(m_phase == 0));
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Runs edges first..last and returns a bitmask of the edges that produced a pulse.
  task automatic run_edges(input int first, input int last, output logic [31:0] mask);
    mask = '0;
    for (int e = first; e <= last; e++) begin
      step();
      if (pulse_out) mask[e] = 1'b1;
    end
  endtask

  task automatic cfg_and_step(input int div, input int burst);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(div);
    cfg_burst = BURST_W'(burst);
    step();
    cfg_valid = 1'b0;
  endtask

  logic [31:0] mask;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pulse_out", 32'(pulse_out), 0);
    check("rst_busy",      32'(busy),      0);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_pulse_cnt", 32'(pulse_cnt), 0);
    rst_n = 1'b1;

    // Default divisor 1000/100 = 10, continuous.
    start = 1'b1; step(); start = 1'b0;
    check("def_busy_e0", 32'(busy), 1);
    run_edges(1, 30, mask);
    check("def_pulse_edges", mask, 32'h4010_0400);
    check("def_pulse_cnt", 32'(pulse_cnt), 3);
    stop = 1'b1; step(); stop = 1'b0;

    // Burst of 3 at divisor 4.
    cfg_and_step(4, 3);
    start = 1'b1; step(); start = 1'b0;
    run_edges(1, 12, mask);
    check("burst_pulse_edges", mask, 32'h0000_1110);
    check("burst_done_e12", 32'(done), 1);
    check("burst_cnt_e12", 32'(pulse_cnt), 3);
    check("burst_busy_e12", 32'(busy), 0);
    check("burst_ready_e12", 32'(cfg_ready), 0);
    step();
    check("burst_done_e13", 32'(done), 0);
    check("burst_ready_e13", 32'(cfg_ready), 1);

    // Stop on the edge that would have issued the second pulse.
    cfg_and_step(5, 0);
    start = 1'b1; step(); start = 1'b0;
    run_edges(1, 9, mask);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_pulse", 32'(pulse_out), 0);
    check("stop_busy", 32'(busy), 0);
    check("stop_done", 32'(done), 0);
    check("stop_cnt_held", 32'(pulse_cnt), 1);

    // Illegal config keeps div=5, burst=0.
    cfg_and_step(0, 2);
    check("illegal_err", 32'(err), 1);
    start = 1'b1; step(); start = 1'b0;
    run_edges(1, 10, mask);
    check("illegal_old_div", mask, 32'h0000_0420);
    check("illegal_old_burst", 32'(busy), 1);
    stop = 1'b1; step(); stop = 1'b0;
    cfg_and_step(3, 1);
    check("legal_clears_err", 32'(err), 0);
    start = 1'b1; step(); start = 1'b0;
    cfg_valid = 1'b1; cfg_div = CNT_W'(7); cfg_burst = '0;
    check("run_cfg_ready", 32'(cfg_ready), 0);
    run_edges(1, 3, mask);
    cfg_valid = 1'b0;
    check("run_cfg_ignored", mask, 32'h0000_0008);
    check("run_cfg_done", 32'(done), 1);
    step();

    // Same-cycle config and start.
    cfg_valid = 1'b1; cfg_div = CNT_W'(2); cfg_burst = BURST_W'(2); start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    run_edges(1, 4, mask);
    check("same_cycle_edges", mask, 32'h0000_0014);
    check("same_cycle_done", 32'(done), 1);
    step();

    // Divisor 1 pulses every edge; pulse_cnt wraps at 16.
    cfg_valid = 1'b1; cfg_div = CNT_W'(1); cfg_burst = '0; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    run_edges(1, 17, mask);
    check("div1_every_edge", mask, 32'h0003_fffe);
    check("div1_wrap_cnt", 32'(pulse_cnt), 1);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", 32'(pulse_out), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_cnt", 32'(pulse_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    run_edges(1, 10, mask);
    check("arst_default_div", mask, 32'h0000_0400);
    stop = 1'b1; step(); stop = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_div   = CNT_W'($urandom_range(0, 6));
      cfg_burst = BURST_W'($urandom_range(0, 5));
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand_arst_busy", 32'(busy), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
